// File: rtl/cpu_pkg.sv
// Shared decode-path constants and the bypass selection record.
package cpu_pkg;

    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int REG_ZERO  = 0;
    localparam int SRC_IDX_W = 4;

    typedef struct packed {
        logic                 use_rf;
        logic [SRC_IDX_W-1:0] src;
    } bypass_sel_t;

endpackage

// File: rtl/bypass_select.sv
// Priority operand bypass: the youngest matching source wins, else the regfile value.
module bypass_select
    import cpu_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic [AW-1:0]      idx,
    input  logic [DW-1:0]      rf_data,
    input  logic [NSRC-1:0]    src_we,
    input  logic [NSRC*AW-1:0] src_reg,
    input  logic [NSRC-1:0]    src_rdy,
    input  logic [NSRC*DW-1:0] src_data,
    output logic [DW-1:0]      data,
    output logic               pending
);

    bypass_sel_t sel;

    always_comb begin
        sel = '{use_rf: 1'b1, src: '0};
        for (int i = 0; i < NSRC; i++) begin
            if (sel.use_rf && src_we[i] && src_reg[i*AW +: AW] == idx
                && idx != AW'(REG_ZERO)) begin
                sel.use_rf = 1'b0;
                sel.src    = SRC_IDX_W'(i);
            end
        end
    end

    // A pending winner is reported as such even if an older source is ready.
    always_comb begin
        data    = rf_data;
        pending = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (!sel.use_rf && sel.src == SRC_IDX_W'(i)) begin
                data    = src_data[i*DW +: DW];
                pending = !src_rdy[i];
            end
        end
    end

endmodule

// File: rtl/id_operand_bypass.sv
// ID->EXE operand stage with N-source bypass, load-use stall and back-pressure.
// Optional ID_STALL_CNT_EN adds a saturating stall-cycle counter.
//   state      | meaning
//   ST_EMPTY   | out_valid=0, no hazard last cycle
//   ST_FULL    | out_valid=1, waiting for out_ready
//   ST_STALL_E | empty output, decode blocked by hazard
//   ST_STALL_F | full output, decode blocked by hazard
module id_operand_bypass
    import cpu_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int DW   = DW_DEF,
    parameter int AW   = AW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [AW-1:0]      in_rs,
    input  logic [AW-1:0]      in_rt,
    input  logic [DW-1:0]      in_qa,
    input  logic [DW-1:0]      in_qb,
    input  logic [NSRC-1:0]    src_we,
    input  logic [NSRC*AW-1:0] src_reg,
    input  logic [NSRC-1:0]    src_rdy,
    input  logic [NSRC*DW-1:0] src_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_da,
    output logic [DW-1:0]      out_db,
`ifdef ID_STALL_CNT_EN
    input  logic               stall_cnt_clr,
    output logic [31:0]        stall_cycles,
`endif
    output logic               stall
);

    // Encoding is {out_valid, stall flag}.
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_STALL_E = 2'b01,
        ST_FULL    = 2'b10,
        ST_STALL_F = 2'b11
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   da_q, da_d, db_q, db_d;
    logic [DW-1:0]   a_data, b_data;
    logic            a_pend, b_pend;
    logic            hazard, accept, ov_n;

    bypass_select #(.NSRC(NSRC), .DW(DW), .AW(AW)) u_sel_rs (
        .idx(in_rs), .rf_data(in_qa), .src_we(src_we), .src_reg(src_reg),
        .src_rdy(src_rdy), .src_data(src_data), .data(a_data), .pending(a_pend)
    );

    bypass_select #(.NSRC(NSRC), .DW(DW), .AW(AW)) u_sel_rt (
        .idx(in_rt), .rf_data(in_qb), .src_we(src_we), .src_reg(src_reg),
        .src_rdy(src_rdy), .src_data(src_data), .data(b_data), .pending(b_pend)
    );

    assign hazard    = a_pend || b_pend;
    assign out_valid = (state_q == ST_FULL) || (state_q == ST_STALL_F);
    assign in_ready  = !hazard && (!out_valid || out_ready);
    assign stall     = in_valid && hazard;
    assign accept    = in_valid && in_ready;
    assign out_da    = da_q;
    assign out_db    = db_q;

    always_comb begin
        ov_n = 1'b0;
        da_d = da_q;
        db_d = db_q;
        case (state_q)
            ST_EMPTY, ST_STALL_E: ov_n = accept;
            ST_FULL, ST_STALL_F:  ov_n = accept || !out_ready;
            default:              ov_n = 1'b0;
        endcase
        // flush wins over a same-cycle accept; operand registers keep their value.
        if (flush) begin
            ov_n = 1'b0;
        end else if (accept) begin
            da_d = a_data;
            db_d = b_data;
        end
        state_d = state_t'({ov_n, stall && !flush});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            da_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            da_q    <= da_d;
            db_q    <= db_d;
        end
    end

`ifdef ID_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_cnt_clr) begin
            stall_cycles_d = '0;
        end else if (stall && stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
